// File: rtl/smvm_batch_scheduler_if.sv
// Bus interfaces for smvm_batch_scheduler.
//   smvm_entry_if : serial matrix-entry stream (producer = master).
//                   s_valid/s_ready, s_val, s_col, s_ipv (row end), s_last (job end)
//   smvm_batch_if : K-lane batch towards the ALU/map-table stage (scheduler = master).
//                   alu_valid/alu_ready, alu_val, alu_col, alu_ipv, alu_vov, alu_last
// Lane 0 sits in the MSBs of every packed lane bus.
interface smvm_entry_if #(
   parameter int VAL_W = 8,
   parameter int IDX_W = 12
);
   logic             s_valid;
   logic             s_ready;
   logic [VAL_W-1:0] s_val;
   logic [IDX_W-1:0] s_col;
   logic             s_ipv;
   logic             s_last;

   modport master (output s_valid, s_val, s_col, s_ipv, s_last, input s_ready);
   modport slave  (input s_valid, s_val, s_col, s_ipv, s_last, output s_ready);
endinterface

interface smvm_batch_if #(
   parameter int K     = 4,
   parameter int VAL_W = 8,
   parameter int IDX_W = 12
);
   logic               alu_valid;
   logic               alu_ready;
   logic [K*VAL_W-1:0] alu_val;
   logic [K*IDX_W-1:0] alu_col;
   logic [K-1:0]       alu_ipv;
   logic [2:0]         alu_vov;
   logic               alu_last;

   modport master (output alu_valid, alu_val, alu_col, alu_ipv, alu_vov, alu_last,
                   input alu_ready);
   modport slave  (input alu_valid, alu_val, alu_col, alu_ipv, alu_vov, alu_last,
                   output alu_ready);
endinterface

// File: rtl/smvm_batch_scheduler.sv
// smvm_batch_scheduler
// Packs the serial matrix-entry stream into K-lane batches for the SMVM ALU
// tree, zero-pads the final partial batch, issues batches over valid/ready,
// counts rows issued and waits out the ALU pipeline before flagging job end.
// Ports:
//   clk, rst       clock (rising edge), asynchronous active-high reset
//   cfg_start      one-cycle job start pulse (honoured only when idle)
//   cfg_rows       expected number of row-end entries in the job
//   entry          entry stream (slave side)
//   batch          batch bus to the ALU stage (master side)
//   rows_done      rows issued so far in this job (saturating)
//   busy           job in progress
//   done           one-cycle pulse once the last batch has drained
//   err            sticky row-count / termination error, cleared by cfg_start
//   state_dbg      current FSM state for observation
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. The sender holds valid and all payload stable until that edge;
// ready carries no obligation while valid is low.
module smvm_batch_scheduler #(
   parameter int K       = 4,
   parameter int VAL_W   = 8,
   parameter int IDX_W   = 12,
   parameter int ALU_LAT = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cfg_start,
   input  logic [IDX_W-1:0] cfg_rows,
   smvm_entry_if.slave      entry,
   smvm_batch_if.master     batch,
   output logic [IDX_W-1:0] rows_done,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic [1:0]       state_dbg
);
   localparam int LW = (K > 1) ? $clog2(K) : 1;
   localparam int DW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
   localparam logic [LW-1:0]  LAST_LANE = LW'(K - 1);
   localparam logic [DW-1:0]  DRAIN_END = DW'(ALU_LAT - 1);
   localparam logic [IDX_W:0] ROWS_MAX  = {1'b0, {IDX_W{1'b1}}};

   typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1, ISSUE = 2'd2, DRAIN = 2'd3} state_t;
   state_t state, state_nxt;

   logic [VAL_W-1:0] lane_val [K];
   logic [IDX_W-1:0] lane_col [K];
   logic             lane_ipv [K];
   logic [LW-1:0]    lane_cnt;
   logic [2:0]       vov;
   logic             last_flag;
   logic             last_ipv;
   logic             err_q;
   logic [IDX_W-1:0] rows_tgt;
   logic [DW-1:0]    drain_cnt;
   logic [IDX_W:0]   rows_sum;
   logic             start, accept, issue_hs, err_now;

   assign state_dbg = state;
   assign start     = (state == IDLE) && cfg_start;
   assign accept    = entry.s_valid && entry.s_ready;
   assign issue_hs  = batch.alu_valid && batch.alu_ready;
   assign rows_sum  = {1'b0, rows_done} + (IDX_W+1)'(vov);
   // Job-end checks are evaluated on the done cycle and made visible at once.
   assign err_now   = done && ((rows_done != rows_tgt) || !last_ipv);
   assign err       = err_q || err_now;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt       = state;
      entry.s_ready   = 1'b0;
      batch.alu_valid = 1'b0;
      done            = 1'b0;
      busy            = (state != IDLE);
      case (state)
         IDLE:  if (cfg_start) state_nxt = FILL;
         FILL: begin
            entry.s_ready = 1'b1;
            if (entry.s_valid && ((lane_cnt == LAST_LANE) || entry.s_last))
               state_nxt = ISSUE;
         end
         ISSUE: begin
            batch.alu_valid = 1'b1;
            if (batch.alu_ready) state_nxt = last_flag ? DRAIN : FILL;
         end
         DRAIN: begin
            if (drain_cnt == DRAIN_END) begin
               done      = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Batch outputs come straight from the lane registers, so they are stable
   // for the whole ISSUE period and read zero on lanes never written.
   always_comb begin
      batch.alu_val = '0;
      batch.alu_col = '0;
      batch.alu_ipv = '0;
      for (int i = 0; i < K; i++) begin
         batch.alu_val[(K-1-i)*VAL_W +: VAL_W] = lane_val[i];
         batch.alu_col[(K-1-i)*IDX_W +: IDX_W] = lane_col[i];
         batch.alu_ipv[K-1-i]                  = lane_ipv[i];
      end
      batch.alu_vov  = vov;
      batch.alu_last = last_flag;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < K; i++) begin
            lane_val[i] <= '0;
            lane_col[i] <= '0;
            lane_ipv[i] <= 1'b0;
         end
         lane_cnt  <= '0;
         vov       <= '0;
         last_flag <= 1'b0;
         last_ipv  <= 1'b0;
         err_q     <= 1'b0;
         rows_tgt  <= '0;
         rows_done <= '0;
         drain_cnt <= '0;
      end else begin
         if (start || issue_hs) begin
            // Clearing on issue is what zero-pads a later partial batch.
            for (int i = 0; i < K; i++) begin
               lane_val[i] <= '0;
               lane_col[i] <= '0;
               lane_ipv[i] <= 1'b0;
            end
            lane_cnt  <= '0;
            vov       <= '0;
            last_flag <= 1'b0;
         end else if (accept) begin
            lane_val[lane_cnt] <= entry.s_val;
            lane_col[lane_cnt] <= entry.s_col;
            lane_ipv[lane_cnt] <= entry.s_ipv;
            lane_cnt           <= lane_cnt + 1'b1;
            vov                <= vov + 3'(entry.s_ipv);
            if (entry.s_last) begin
               last_flag <= 1'b1;
               last_ipv  <= entry.s_ipv;
            end
         end

         if (start) begin
            rows_tgt  <= cfg_rows;
            rows_done <= '0;
            err_q     <= 1'b0;
            last_ipv  <= 1'b0;
         end else if (issue_hs) begin
            if (rows_sum >= ROWS_MAX) begin
               rows_done <= ROWS_MAX[IDX_W-1:0];
               err_q     <= 1'b1;
            end else begin
               rows_done <= rows_sum[IDX_W-1:0];
            end
         end else if (err_now) begin
            err_q <= 1'b1;
         end

         if (state == DRAIN) drain_cnt <= drain_cnt + 1'b1;
         else                drain_cnt <= '0;
      end
   end
endmodule

// File: doc/smvm_batch_scheduler.md
# smvm_batch_scheduler

Sequencing controller in front of the SMVM ALU tree. Accepts the serial matrix-entry stream (value, column index, row-end IPV flag), packs it into K-lane batches, and zero-pads the final partial batch. Issues each batch to the L1 ALU/map-table stage over a valid/ready handshake, counts completed rows, and waits out the ALU pipeline before signalling job completion.

## Interface
- K, 4, lanes per ALU batch
- VAL_W, 8, matrix value width (signed)
- IDX_W, 12, column index / row count width
- ALU_LAT, 4, cycles from batch handshake to last ALU result; drain length
- clk  in  1  clock, rising edge
- rst  in  1  reset; one clock, asynchronous, active-high
- cfg_start  in  1  one-cycle job start pulse
- cfg_rows  in  IDX_W  expected number of rows (IPV=1 entries) in the job
- s_valid  in  1  entry valid
- s_ready  out  1  entry accepted when s_valid & s_ready
- s_val  in  VAL_W  matrix value
- s_col  in  IDX_W  column index
- s_ipv  in  1  entry ends a row
- s_last  in  1  final entry of job
- alu_valid  out  1  batch valid
- alu_ready  in  1  ALU accepts batch
- alu_val  out  K*VAL_W  lane values; lane 0 in MSBs
- alu_col  out  K*IDX_W  lane column indices; lane 0 in MSBs
- alu_ipv  out  K  lane IPV bits; lane 0 in MSB
- alu_vov  out  3  popcount of alu_ipv (rows ending in batch)
- alu_last  out  1  batch is the job's final batch
- rows_done  out  IDX_W  rows issued so far in this job
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse at job end
- err  out  1  sticky until next cfg_start: row-count mismatch

## Operation
- States: IDLE, FILL, ISSUE, DRAIN.
- IDLE:
  - s_ready=0; s_valid ignored.
  - cfg_start latches cfg_rows, clears rows_done, err and lane count, then goes to FILL.
- FILL:
  - s_ready=1. Each accepted entry is written to lane `lane_cnt`, then lane_cnt increments.
  - Go to ISSUE on accepting lane K-1, or on accepting an entry with s_last=1.
  - On s_last at lane j<K-1: lanes j+1..K-1 become val=0, col=0, ipv=0, and alu_last is set.
- ISSUE:
  - s_ready=0; alu_valid=1.
  - All alu_* outputs are held stable until alu_ready.
  - On handshake: rows_done += alu_vov and lane_cnt=0. Go to FILL if not the last batch, otherwise go to DRAIN with drain counter=0.
- DRAIN:
  - Counter increments each cycle. At count ALU_LAT-1, assert done for one cycle and go to IDLE.
  - err is set on the done cycle if rows_done != latched cfg_rows.
  - err is also set on the done cycle if the final real entry had s_ipv=0.
- Lanes are cleared to zero when they are issued, so stale data never appears on padded lanes.
- cfg_start outside IDLE is ignored.
- rows_done saturates at 2^IDX_W-1; reaching saturation sets err.

## Timing
- Reset values:
  - s_ready=0, alu_valid=0, alu_val/col/ipv=0, alu_vov=0, alu_last=0.
  - rows_done=0, busy=0, done=0, err=0; state=IDLE.
- rst assertion mid-job aborts immediately (asynchronous): all of the above values, and any partial batch is discarded.
- cfg_start at edge t: busy=1 and s_ready=1 from t+1.
- Full batch: K accepts on consecutive cycles t..t+K-1, then alu_valid=1 from t+K.
  - With alu_ready=1, the handshake is at t+K and s_ready=1 again at t+K+1.
  - Sustained throughput is K entries per K+1 cycles.
- alu_vov and alu_ipv are registered with the batch; they are valid whenever alu_valid=1.
- rows_done updates the cycle after the handshake.
- Last-batch handshake at t: done=1 at t+ALU_LAT, busy=0 at t+ALU_LAT+1.
- alu_ready high while alu_valid=0: no effect.
- s_valid low in FILL: no state change, lane_cnt holds.

## Test plan
- Reset mid-FILL after 2 entries:
  - Outputs return to reset values within the reset cycle.
  - After reset, cfg_start plus 4 entries yields one batch containing only the new data.
- cfg_rows=2; 8 entries (vals 1..8, cols 0..7), ipv=1 on entries 4 and 8, s_last on 8, alu_ready=1:
  - Two batches: first alu_val={1,2,3,4}, alu_ipv=0001, alu_vov=1; second alu_last=1, alu_vov=1.
  - done 4 cycles after the second handshake; rows_done=2, err=0.
- cfg_rows=1; 3 entries (vals 5,6,7), ipv=1 and s_last on the third:
  - One batch alu_val={5,6,7,0}, alu_col lane 3=0, alu_ipv=0010, alu_vov=1, alu_last=1.
- Backpressure: hold alu_ready=0 for 5 cycles during ISSUE.
  - alu_* outputs stable throughout; s_ready=0; no entry lost.
  - Handshake on the first cycle alu_ready=1.
- cfg_rows=3 but only 2 ipv=1 entries in the job: done pulses with err=1; err clears on the next cfg_start.
- cfg_start pulsed during DRAIN: ignored. Exactly one done; a following cfg_start in IDLE starts a new job.
